// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: sequencing controller for the shared bidirectional memory
// data bus of the multicycle MIPS core. Accepts one read or write at a time,
// drives the bus switch direction/write data and the active-low memory
// strobes, inserts turnaround cycles on every direction change and returns
// read data with a one-cycle response pulse.
//
// Optional feature: define MEMBUS_ALIGN_CHECK_EN to reject word-misaligned
// requests with rsp_err. The port list is identical in both builds.
module mem_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2,   // strobe-active cycles per access, 1..255
    parameter int TURN_CYCLES = 1    // idle cycles on direction change, 1..255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_dir,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TURN   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counters count down to zero, so they are loaded with N-1.
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);
    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              op_we, op_we_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] bus_wdata_nx;
    logic              bus_dir_nx;
    logic              rsp_err_nx;
    logic              capture;
    logic              accept;
    logic              misaligned;
    logic              same_dir;

`ifdef MEMBUS_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign accept   = req_valid && req_ready;
    // A read needs bus_dir=1 and a write needs bus_dir=0.
    assign same_dir = (req_we != bus_dir);

    // Next-state, counter and datapath-register decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_nx     = state;
        cnt_nx       = cnt;
        op_we_nx     = op_we;
        mem_addr_nx  = mem_addr;
        bus_wdata_nx = bus_wdata;
        rsp_err_nx   = 1'b0;
        capture      = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    op_we_nx    = req_we;
                    mem_addr_nx = req_addr;
                    if (misaligned) begin
                        // Rejected: straight to the response, bus untouched.
                        state_nx   = DONE;
                        rsp_err_nx = 1'b1;
                    end else begin
                        // Write data only changes for real writes, so a read
                        // after a write does not disturb the held bus value.
                        if (req_we) bus_wdata_nx = req_wdata;
                        if (same_dir) begin
                            state_nx = ACCESS;
                            cnt_nx   = WAIT_LOAD;
                        end else begin
                            state_nx = TURN;
                            cnt_nx   = TURN_LOAD;
                        end
                    end
                end
            end
            TURN: begin
                if (cnt == 8'd0) begin
                    state_nx = ACCESS;
                    cnt_nx   = WAIT_LOAD;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            ACCESS: begin
                if (cnt == 8'd0) begin
                    state_nx = DONE;
                    capture  = !op_we;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus direction is sticky: a read flips it to 1 as soon as TURN starts,
    // a write only flips it to 0 when ACCESS starts.
    always_comb begin
        bus_dir_nx = bus_dir;
        if (state_nx == ACCESS)
            bus_dir_nx = !op_we_nx;
        else if (state_nx == TURN && !op_we_nx)
            bus_dir_nx = 1'b1;
    end

    // State and control register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
            op_we <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nx;
            cnt   <= cnt_nx;
            op_we <= op_we_nx;
        end
    end

    // Registered outputs, decoded from the next state so they change exactly
    // on the edge the state does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            bus_dir   <= 1'b1;
            bus_wdata <= '0;
            mem_addr  <= '0;
            mem_ce_n  <= 1'b1;
            mem_oe_n  <= 1'b1;
            mem_we_n  <= 1'b1;
        end else begin
            req_ready <= (state_nx == IDLE);
            rsp_valid <= (state_nx == DONE);
            rsp_err   <= rsp_err_nx;
            bus_dir   <= bus_dir_nx;
            bus_wdata <= bus_wdata_nx;
            mem_addr  <= mem_addr_nx;
            mem_ce_n  <= !(state_nx == ACCESS);
            mem_oe_n  <= !(state_nx == ACCESS && !op_we_nx);
            mem_we_n  <= !(state_nx == ACCESS && op_we_nx);
            if (capture) rsp_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: scoreboard bench for mem_bus_ctrl. A driver issues
// requests and pushes the expected response; a monitor pops and compares on
// every rsp_valid. A simple memory device sits on the bus side.
module tb_mem_bus_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int W  = 2;
    localparam int T  = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          bus_dir;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_ce_n, mem_oe_n, mem_we_n;

    mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .TURN_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_dir(bus_dir), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int accepted  = 0;
    int responses = 0;
    int last_accept = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    // Unwritten locations read back an address-derived pattern.
    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory device on the bus side ----------------
    logic [31:0] dev_mem [logic [31:0]];

    initial begin
        forever begin
            @(negedge clk);
            if (!mem_we_n && !mem_ce_n) dev_mem[mem_addr] = bus_wdata;
            if (!mem_oe_n)
                bus_rdata = dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : fill(mem_addr);
            else
                bus_rdata = $urandom;
        end
    end

    // ---------------- reference model ----------------
    logic        model_dir  = 1'b1;  // 1 = bus set up for reads
    logic [31:0] model_last = '0;
    logic [31:0] model_mem [logic [31:0]];

    function automatic logic model_misaligned(input logic [31:0] a);
`ifdef MEMBUS_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   guard;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        guard = 0;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (model_misaligned(addr)) begin
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.err = 1'b0;
            e.lat = W + 1 + (((!we) != model_dir) ? T : 0);
            model_dir = !we;
            if (we) model_mem[addr] = wdata;
            else model_last = model_mem.exists(addr) ? model_mem[addr] : fill(addr);
        end
        e.rdata     = model_last;
        e.acc_cyc   = cyc + 1;
        last_accept = cyc + 1;
        exp_q.push_back(e);
        accepted++;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            check("no_contention", {63'b0, (!bus_dir && !mem_oe_n)}, 64'd0);
            if (rsp_valid) begin
                responses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_latency", cyc - e.acc_cyc + 1, e.lat);
                end
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a0;
        logic        we;
        logic [31:0] addr;

        dev_mem[32'h100]   = 32'hDEAD_BEEF;
        model_mem[32'h100] = 32'hDEAD_BEEF;

        // Reset values
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_bus_dir", bus_dir, 1);
        check("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Read after reset: no turnaround
        issue(1'b0, 32'h100, 32'h0);
        @(negedge clk);
        check("rd_c1_oe_n", mem_oe_n, 0);
        check("rd_c1_ce_n", mem_ce_n, 0);
        check("rd_c1_addr", mem_addr, 32'h100);
        @(negedge clk);
        check("rd_c2_oe_n", mem_oe_n, 0);

        // Write after read: one TURN cycle, then write strobes
        issue(1'b1, 32'h104, 32'hCAFE_F00D);
        @(negedge clk);
        check("wr_turn_dir", bus_dir, 1);
        check("wr_turn_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
        @(negedge clk);
        check("wr_c2_dir", bus_dir, 0);
        check("wr_c2_we_n", mem_we_n, 0);
        check("wr_c2_wdata", bus_wdata, 32'hCAFE_F00D);
        check("wr_c2_addr", mem_addr, 32'h104);
        @(negedge clk);
        check("wr_c3_we_n", mem_we_n, 0);
        check("wr_c3_dir", bus_dir, 0);

        // Write after write: latency 3 (monitor)
        issue(1'b1, 32'h108, 32'h1234_5678);

        // Read after write: bus_dir back to 1 before mem_oe_n falls
        issue(1'b0, 32'h104, 32'h0);
        @(negedge clk);
        check("rd_turn_dir", bus_dir, 1);
        check("rd_turn_oe_n", mem_oe_n, 1);
        @(negedge clk);
        check("rd_after_turn_oe_n", mem_oe_n, 0);

        // Back-to-back same-direction throughput
        issue(1'b0, 32'h100, 32'h0);
        a0 = last_accept;
        issue(1'b0, 32'h108, 32'h0);
        check("b2b_period", last_accept - a0, W + 2);

        // Misaligned read
        issue(1'b0, 32'h102, 32'h0);
        @(negedge clk);
        check("mis_c1_ce_n", mem_ce_n, model_misaligned(32'h102) ? 1 : 0);
        drain();

        // Random mix
        for (int i = 0; i < 1000; i++) begin
            we   = 1'($urandom);
            addr = ($urandom % 8) << 2;
            if ($urandom % 8 == 0) addr = addr + 32'($urandom_range(1, 3));
            issue(we, addr, $urandom);
            if ($urandom % 4 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // Reset during the second ACCESS cycle of a write
        issue(1'b0, 32'h200, 32'h0);
        drain();
        issue(1'b1, 32'h200, 32'h5555_AAAA);
        @(negedge clk);  // TURN
        @(negedge clk);  // ACCESS 1
        @(negedge clk);  // ACCESS 2
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we_n", mem_we_n, 1);
        check("abort_ce_n", mem_ce_n, 1);
        check("abort_bus_dir", bus_dir, 1);
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_req_ready", req_ready, 1);
        exp_q.delete();
        accepted--;
        model_dir  = 1'b1;
        model_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);  // monitor flags any stray rsp_valid

        // Controller still works after the abort
        issue(1'b0, 32'h104, 32'h0);
        drain();
        check("rsp_count", responses, accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
